// File: rtl/fetch_stage_btb.sv
// Fetch stage with a direct-mapped branch target buffer, a single-entry skid
// register for back-pressure, and EX-driven redirect/update paths.
module fetch_stage_btb #(
    parameter int                WORD_W      = 16,
    parameter int                BTB_ENTRIES = 8,
    parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset_n,

    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,

    input  logic              stall,
    output logic              valid_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] pred_pc_out,

    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,

    input  logic              upd_en,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W;

    typedef enum logic {
        S_REQ,
        S_HOLD
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] pc;

    logic [WORD_W-1:0] skid_pc;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_pred;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [WORD_W-1:0]      btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_hit;
    logic [WORD_W-1:0] pred_pc;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    logic              slot_free;

    assign fetch_idx = pc[IDX_W-1:0];
    assign fetch_tag = pc[WORD_W-1:IDX_W];
    assign fetch_hit = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);

    // Lookup sees pre-edge BTB contents, so a same-cycle update only affects later fetches.
    always_comb begin
        pred_pc = pc + WORD_W'(1);
        if (fetch_hit && btb_ctr[fetch_idx][1]) begin
            pred_pc = btb_target[fetch_idx];
        end
    end

    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[WORD_W-1:IDX_W];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btb_valid <= '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (btb_ctr[upd_idx] != 2'd3) begin
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                    end
                    btb_target[upd_idx] <= upd_target;
                end else if (btb_ctr[upd_idx] != 2'd0) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
                btb_ctr[upd_idx]    <= 2'd2;
            end
        end
    end

    assign slot_free = !valid_out || !stall;
    assign imem_req  = reset_n && (state == S_REQ);
    assign imem_addr = pc;

    // A response that cannot enter a stalled output register parks in the skid
    // register; HOLD stops requesting until decode drains the output slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            valid_out   <= 1'b0;
            pc_out      <= '0;
            instr_out   <= '0;
            pred_pc_out <= '0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            skid_pred   <= '0;
        end else if (redirect) begin
            state      <= S_REQ;
            pc         <= redirect_pc;
            valid_out  <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            skid_pred  <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        pc <= pred_pc;
                        if (slot_free) begin
                            valid_out   <= 1'b1;
                            pc_out      <= pc;
                            instr_out   <= imem_rdata;
                            pred_pc_out <= pred_pc;
                        end else begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            skid_pred  <= pred_pc;
                            state      <= S_HOLD;
                        end
                    end else if (!stall) begin
                        valid_out <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_out   <= 1'b1;
                        pc_out      <= skid_pc;
                        instr_out   <= skid_instr;
                        pred_pc_out <= skid_pred;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage_btb.md
FETCH_STAGE_BTB -- requirements
Module: fetch_stage_btb

Interface
REQ-001 The block SHALL take parameter WORD_W, default 16: instruction and address width.
REQ-002 The block SHALL take parameter BTB_ENTRIES, default 8, power of two >= 2: number of direct-mapped BTB entries.
REQ-003 The block SHALL take parameter RESET_PC, default 0: PC loaded at reset.
REQ-004 The block SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have ports imem_req output 1, imem_addr output WORD_W, imem_ready input 1, imem_rdata input WORD_W: instruction memory request/response.
REQ-007 The block SHALL have ports stall input 1, valid_out output 1, pc_out output WORD_W, instr_out output WORD_W, pred_pc_out output WORD_W: decode-side output register; a transfer occurs when valid_out=1 and stall=0.
REQ-008 The block SHALL have ports redirect input 1 and redirect_pc input WORD_W: EX-stage misprediction correction.
REQ-009 The block SHALL have ports upd_en input 1, upd_pc input WORD_W, upd_target input WORD_W, upd_taken input 1: resolved-branch BTB update from EX.

Function
REQ-010 BTB entry: valid bit, tag = pc[WORD_W-1:log2(BTB_ENTRIES)], target WORD_W, 2-bit saturating counter; index = pc[log2(BTB_ENTRIES)-1:0].
REQ-011 Prediction for fetch PC p: entry at index(p) valid, tag match, counter >= 2 -> target; otherwise p+1, wrapping modulo 2^WORD_W.
REQ-012 Lookup SHALL be combinational on pre-edge BTB contents; an update to the same index in the same cycle affects only later lookups.
REQ-013 Update, upd_en=1: hit + taken -> counter+1 saturating at 3, target <= upd_target; hit + not taken -> counter-1 saturating at 0; miss + taken -> allocate/overwrite with valid=1, new tag, target, counter=2; miss + not taken -> no change.
REQ-014 FSM states: REQ, HOLD.
REQ-015 REQ: imem_req=1, imem_addr=PC; imem_addr SHALL stay stable until imem_ready or redirect.
REQ-016 REQ with imem_ready=1 and output slot free (valid_out=0 or stall=0): output register <= {1, PC, imem_rdata, prediction(PC)}; PC <= prediction(PC); stay REQ.
REQ-017 REQ with imem_ready=1 and slot busy (valid_out=1 and stall=1): skid register <= {PC, imem_rdata, prediction(PC)}; PC <= prediction(PC); go HOLD.
REQ-018 REQ with imem_ready=0 and stall=0: valid_out <= 0 at the edge.
REQ-019 HOLD: imem_req=0; when stall=0, output register <= skid contents with valid_out=1; go REQ.
REQ-020 Output register SHALL hold all fields unchanged while valid_out=1 and stall=1; no instruction SHALL be lost or duplicated.
REQ-021 redirect=1 SHALL override all other transitions, in any state: PC <= redirect_pc, valid_out <= 0, skid discarded, state <= REQ; imem_ready/imem_rdata in that cycle ignored.
REQ-022 The cycle after redirect, imem_req=1 with imem_addr=redirect_pc; the memory treats it as a new request.
REQ-023 Latency: imem_ready at edge N -> valid_out=1 after edge N when the slot is free; sustained throughput 1 instruction/cycle with single-cycle memory.
REQ-024 upd_en SHALL be processed independently of redirect and stall, including in the same cycle.

Reset
REQ-025 While reset_n=0 at an edge: PC <= RESET_PC, state <= REQ, valid_out <= 0, all BTB valid bits <= 0, skid cleared; imem_req SHALL be 0 while reset_n=0.
REQ-026 Reset asserted mid-request or in HOLD SHALL abandon any pending response; the first request after reset SHALL use address RESET_PC.
REQ-027 Reset-visible outputs: valid_out=0, pc_out=0, instr_out=0, pred_pc_out=0.

Verification
REQ-028 Reset release, imem_ready tied 1, rdata=addr+100, stall=0 -> pc_out 0,1,2,3 on consecutive cycles; instr_out 100,101,...; pred_pc_out=pc_out+1.
REQ-029 upd_en with upd_pc=4, target=20, taken=1; then fetch through 4 -> pred_pc_out=20 at pc_out=4; next pc_out=20.
REQ-030 Two not-taken updates at pc 4 after allocation -> counter 0; prediction from 4 falls back to 5.
REQ-031 stall=1 for 3 cycles while responses keep arriving -> output frozen, one response held in skid, imem_req=0 in HOLD; after release, sequence is continuous with no gap or duplicate.
REQ-032 redirect=1, redirect_pc=0x40, in the same cycle as imem_ready -> valid_out=0 next cycle, imem_addr=0x40; dropped data never appears on instr_out.
REQ-033 Aliasing: pc 3 and pc 11 (BTB_ENTRIES=8) taken updates -> second overwrites; pc 3 then predicts 4.
